// File: rtl/encoded_word_serializer_if.sv
// Handshake bundle between a word source and the encoded word serializer.
// The master supplies load/word_in; the slave (the serializer) returns the bit stream.
interface encoded_word_serializer_if #(
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(WIDTH);

  logic          load;
  logic [WIDTH-1:0] word_in;
  logic          busy;
  logic          bit_out;
  logic          bit_valid;
  logic [IW-1:0] bit_index;
  logic          done;

  modport master (
    output load, word_in,
    input  busy, bit_out, bit_valid, bit_index, done
  );

  modport slave (
    input  load, word_in,
    output busy, bit_out, bit_valid, bit_index, done
  );
endinterface

// File: rtl/encoded_word_serializer.sv
// Captures one encoded word and presents it MSB first, one bit per HOLD_CYCLES clocks,
// with GAP_CYCLES blank clocks between bits; done pulses once after the last bit.
module encoded_word_serializer #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  encoded_word_serializer_if.slave   bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] TOP_INDEX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, FINISH} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [HW-1:0]    r_hold_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_busy;
  logic             r_bit_out;
  logic             r_bit_valid;
  logic [IW-1:0]    r_bit_index;
  logic             r_done;

  wire              w_last_hold = (r_hold_cnt == HOLD_LAST);
  wire              w_last_gap  = (r_gap_cnt == GAP_LAST);
  wire              w_last_bit  = (r_bit_index == '0);
  wire [WIDTH-1:0]  w_shifted   = {r_shreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_busy      <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_bit_index <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.load) begin
            r_shreg     <= bus.word_in;
            r_bit_index <= TOP_INDEX;
            r_hold_cnt  <= '0;
            r_busy      <= 1'b1;
            r_bit_valid <= 1'b1;
            r_bit_out   <= bus.word_in[WIDTH-1];
            r_state     <= SHOW;
          end
        end
        SHOW: begin
          if (!w_last_hold) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end else if (w_last_bit) begin
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= FINISH;
          end else if (GAP_CYCLES > 0) begin
            r_gap_cnt   <= '0;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_state     <= GAP;
          end else begin
            // No gap: next bit follows immediately with bit_valid kept high.
            r_shreg     <= w_shifted;
            r_bit_out   <= r_shreg[WIDTH-2];
            r_bit_index <= r_bit_index - IW'(1);
            r_hold_cnt  <= '0;
          end
        end
        GAP: begin
          if (w_last_gap) begin
            r_shreg     <= w_shifted;
            r_bit_out   <= r_shreg[WIDTH-2];
            r_bit_valid <= 1'b1;
            r_bit_index <= r_bit_index - IW'(1);
            r_hold_cnt  <= '0;
            r_state     <= SHOW;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        FINISH: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_bit_index <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.bit_out   = r_bit_out;
  assign bus.bit_valid = r_bit_valid;
  assign bus.bit_index = r_bit_index;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_encoded_word_serializer.sv
// Bench for encoded_word_serializer: a per-cycle schedule model plus hand-computed checkpoints.
// Two instances: default timing (A) and HOLD_CYCLES=1, GAP_CYCLES=0 (B).
module tb_encoded_word_serializer;
  localparam int HA = 4, GA = 1, HB = 1, GB = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  encoded_word_serializer_if #(.WIDTH(4)) if_a ();
  encoded_word_serializer_if #(.WIDTH(4)) if_b ();

  encoded_word_serializer #(.WIDTH(4), .HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  encoded_word_serializer #(.WIDTH(4), .HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model state: k = cycles since the capture edge (0 = idle), w = captured word.
  int k_a = 0, k_b = 0;
  logic [3:0] w_a = 4'b0, w_b = 4'b0;

  // Observed outputs packed as {busy, bit_valid, bit_out, done, bit_index[1:0]}.
  logic [5:0] obs_a, obs_b;
  assign obs_a = {if_a.busy, if_a.bit_valid, if_a.bit_out, if_a.done, if_a.bit_index};
  assign obs_b = {if_b.busy, if_b.bit_valid, if_b.bit_out, if_b.done, if_b.bit_index};

  function automatic int trans_len(input int h, input int g);
    return 4 * h + 3 * g + 1;
  endfunction

  // Cycle k of a transfer: bit b = (k-1)/(h+g) shown for the first h cycles of its slot.
  function automatic logic [5:0] model_out(input logic [3:0] w, input int k, input int h, input int g);
    int b, o;
    logic v;
    logic [1:0] idx;
    if (k == 0) return 6'b000000;
    if (k == trans_len(h, g)) return 6'b100100;
    b = (k - 1) / (h + g);
    o = (k - 1) % (h + g);
    v = (o < h);
    idx = 2'(3 - b);
    return {1'b1, v, v & w[idx], 1'b0, idx};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k_a <= 0;
      k_b <= 0;
    end else begin
      if (k_a == 0) begin
        if (if_a.load) begin k_a <= 1; w_a <= if_a.word_in; end
      end else if (k_a == trans_len(HA, GA)) k_a <= 0;
      else k_a <= k_a + 1;
      if (k_b == 0) begin
        if (if_b.load) begin k_b <= 1; w_b <= if_b.word_in; end
      end else if (k_b == trans_len(HB, GB)) k_b <= 0;
      else k_b <= k_b + 1;
    end
  end

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {busy,valid,out,done,idx}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_a", obs_a, model_out(w_a, k_a, HA, GA));
      check("model_b", obs_b, model_out(w_b, k_b, HB, GB));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse load for one edge; returns at the negedge of cycle 1 of the transfer.
  task automatic start_a(input logic [3:0] w);
    @(negedge clk);
    if_a.word_in = w;
    if_a.load = 1'b1;
    @(negedge clk);
    if_a.load = 1'b0;
  endtask

  initial begin
    int dones, d1, d2, restart;
    if_a.load = 1'b0; if_a.word_in = 4'b0;
    if_b.load = 1'b0; if_b.word_in = 4'b0;

    // 1: reset state and idle
    wait_cycles(2);
    check_en = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_a", obs_a, 6'b000000);
    end

    // 2: word 1010 with default timing
    start_a(4'b1010);
    check("t2_c1_bit3", obs_a, 6'b111011);
    wait_cycles(4);
    check("t2_c5_gap", obs_a, 6'b100011);
    wait_cycles(1);
    check("t2_c6_bit2", obs_a, 6'b110010);
    wait_cycles(14);
    check("t2_c20_done", obs_a, 6'b100100);
    wait_cycles(1);
    check("t2_c21_idle", obs_a, 6'b000000);
    wait_cycles(3);

    // 3: second load during bit_index=2 is dropped
    start_a(4'b1010);
    dones = 0;
    wait_cycles(6);
    if_a.word_in = 4'b0101;
    if_a.load = 1'b1;
    @(negedge clk);
    if_a.load = 1'b0;
    for (int c = 8; c <= 45; c++) begin
      @(negedge clk);
      if (if_a.done) dones++;
      if (c == 12) check("t3_c12_bit1", obs_a, 6'b111001);
      if (c == 16) check("t3_c16_bit0", obs_a, 6'b110000);
      if (c == 30) check("t3_c30_idle", obs_a, 6'b000000);
    end
    check_int("t3_done_count", dones, 1);

    // 4: asynchronous reset in the middle of bit_index=1
    start_a(4'b1111);
    wait_cycles(11);
    check("t4_c12_bit1", obs_a, 6'b111001);
    #2 reset = 1'b1;
    #1 check("t4_async_clear", obs_a, 6'b000000);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(2);
    start_a(4'b0001);
    check("t4_c1", obs_a, 6'b110011);
    wait_cycles(5);
    check("t4_c6", obs_a, 6'b110010);
    wait_cycles(5);
    check("t4_c11", obs_a, 6'b110001);
    wait_cycles(5);
    check("t4_c16", obs_a, 6'b111000);
    wait_cycles(4);
    check("t4_c20_done", obs_a, 6'b100100);
    wait_cycles(3);

    // 5: load held high, back-to-back transfers
    @(negedge clk);
    if_a.word_in = 4'b0011;
    if_a.load = 1'b1;
    d1 = 0; d2 = 0; restart = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (restart == 0 && d1 > 0 && if_a.bit_valid) restart = c;
      if (if_a.done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (d2 > 0) break;
    end
    if_a.load = 1'b0;
    check_int("t5_first_done", d1, 20);
    check_int("t5_restart_valid", restart, 22);
    check_int("t5_done_period", d2 - d1, 21);
    for (int c = 0; c < 50 && if_a.busy; c++) @(negedge clk);
    wait_cycles(2);
    check("t5_back_idle", obs_a, 6'b000000);

    // 6: HOLD_CYCLES=1, GAP_CYCLES=0 instance
    @(negedge clk);
    if_b.word_in = 4'b1101;
    if_b.load = 1'b1;
    @(negedge clk);
    if_b.load = 1'b0;
    check("t6_c1", obs_b, 6'b111011);
    wait_cycles(1);
    check("t6_c2", obs_b, 6'b111010);
    wait_cycles(1);
    check("t6_c3", obs_b, 6'b110001);
    wait_cycles(1);
    check("t6_c4", obs_b, 6'b111000);
    wait_cycles(1);
    check("t6_c5_done", obs_b, 6'b100100);
    wait_cycles(1);
    check("t6_c6_idle", obs_b, 6'b000000);
    wait_cycles(3);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
